// File: rtl/mobilenet_pkg.sv
// Shared definitions for the MobileNet datapath: fixed-point format and
// sizing helpers used by stream buffers between layers.
package mobilenet_pkg;

  localparam int FX_N = 16;
  localparam int FX_Q = 8;

  typedef logic signed [FX_N-1:0] fixed_t;

  // Channel tag width; a single-channel stream still carries a 1-bit tag.
  function automatic int ch_width(input int out_channels);
    return (out_channels > 1) ? $clog2(out_channels) : 1;
  endfunction

  function automatic int frame_len(input int out_channels, input int feature_size);
    return out_channels * feature_size * feature_size;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bneck_fifo_mem.sv
// Register-array storage for the bottleneck stream FIFO: one synchronous
// write port and one asynchronous read port.
module bneck_fifo_mem #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents are not reset, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/bneck_stream_fifo.sv
// Elastic buffer after the bottleneck block: absorbs a stream without
// backpressure, re-issues it with valid/ready, checks channel order, marks frames.
module bneck_stream_fifo
  import mobilenet_pkg::*;
#(
  parameter int N            = FX_N,
  parameter int OUT_CHANNELS = 16,
  parameter int FEATURE_SIZE = 56,
  parameter int DEPTH        = 64,
  localparam int CHW = ch_width(OUT_CHANNELS),
  localparam int CW  = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   data_in,
  input  logic [CHW-1:0] channel_in,
  input  logic           valid_in,
  input  logic           ready_in,
  output logic [N-1:0]   data_out,
  output logic [CHW-1:0] channel_out,
  output logic           valid_out,
  output logic [CW-1:0]  count,
  output logic           overflow,
  output logic           channel_error,
  output logic           frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int FL = frame_len(OUT_CHANNELS, FEATURE_SIZE);
  localparam int PW = cnt_width(FL);
  localparam int MW = N + CHW;
  localparam logic [CW-1:0]  FULL_C   = CW'(DEPTH);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(OUT_CHANNELS - 1);
  localparam logic [PW-1:0]  POP_LAST = PW'(FL - 1);

  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic [CHW-1:0] ch_exp_r;
  logic [PW-1:0]  pop_cnt_r;
  logic           overflow_r;
  logic           channel_error_r;
  logic           frame_done_r;

  logic           empty_s;
  logic           full_s;
  logic           push_s;
  logic           pop_s;
  logic           drop_s;
  logic [MW-1:0]  rd_word_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == FULL_C);
  assign valid_out = en & ~empty_s;
  assign pop_s     = valid_out & ready_in;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_s    = en & valid_in & (~full_s | pop_s);
  assign drop_s    = en & valid_in & full_s & ~pop_s;

  bneck_fifo_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({data_in, channel_in}),
    .raddr (rd_ptr_r),
    .rdata (rd_word_s)
  );

  // Head-of-FIFO view; zeroed when empty so stale entries never show.
  always_comb begin
    data_out    = {N{1'b0}};
    channel_out = {CHW{1'b0}};
    if (!empty_s) begin
      {data_out, channel_out} = rd_word_s;
    end else begin
      data_out    = {N{1'b0}};
      channel_out = {CHW{1'b0}};
    end
  end

  // Read/write pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Channel order check on accepted pushes; the tag is stored as received.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_exp_r        <= {CHW{1'b0}};
      channel_error_r <= 1'b0;
    end else if (push_s) begin
      if (channel_in != ch_exp_r) begin
        channel_error_r <= 1'b1;
      end
      ch_exp_r <= (ch_exp_r == CH_LAST) ? {CHW{1'b0}} : ch_exp_r + CHW'(1);
    end
  end

  // Sticky overflow: only an enabled, valid, unaccepted element counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Frame tracking on the output side; pulse follows the last pop of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt_r    <= {PW{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (pop_s) begin
        if (pop_cnt_r == POP_LAST) begin
          pop_cnt_r    <= {PW{1'b0}};
          frame_done_r <= 1'b1;
        end else begin
          pop_cnt_r <= pop_cnt_r + PW'(1);
        end
      end
    end
  end

  assign count         = count_r;
  assign overflow      = overflow_r;
  assign channel_error = channel_error_r;
  assign frame_done    = frame_done_r;

endmodule

// File: tb/tb_bneck_stream_fifo.sv
// Self-checking bench for bneck_stream_fifo: directed scenarios plus a random
// phase, compared each cycle against a queue-based reference model.
module tb_bneck_stream_fifo;

  localparam int N       = 16;
  localparam int DEPTH   = 64;
  localparam int OC      = 16;
  localparam int FL_MAIN = 16 * 56 * 56;
  localparam int FL_F    = 4 * 2 * 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  data_in;
  logic [3:0]    channel_in;
  logic          valid_in;
  logic          ready_in;

  logic [N-1:0]  data_out;
  logic [3:0]    channel_out;
  logic          valid_out;
  logic [6:0]    count;
  logic          overflow;
  logic          channel_error;
  logic          frame_done;

  logic [N-1:0]  data_out_f;
  logic [1:0]    channel_out_f;
  logic          valid_out_f;
  logic [6:0]    count_f;
  logic          overflow_f;
  logic          channel_error_f;
  logic          frame_done_f;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [N+3:0] q[$];
  bit m_ovf = 1'b0, m_cerr = 1'b0, m_cerr_f = 1'b0, m_fd = 1'b0, m_fd_f = 1'b0;
  int ch_exp = 0, pc_main = 0, pc_f = 0, pulses_f = 0;

  always #5 clk = ~clk;

  bneck_stream_fifo #(.N(N), .OUT_CHANNELS(16), .FEATURE_SIZE(56), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .channel_in(channel_in),
    .valid_in(valid_in), .ready_in(ready_in), .data_out(data_out),
    .channel_out(channel_out), .valid_out(valid_out), .count(count),
    .overflow(overflow), .channel_error(channel_error), .frame_done(frame_done)
  );

  bneck_stream_fifo #(.N(N), .OUT_CHANNELS(4), .FEATURE_SIZE(2), .DEPTH(DEPTH)) dut_f (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .channel_in(channel_in[1:0]),
    .valid_in(valid_in), .ready_in(ready_in), .data_out(data_out_f),
    .channel_out(channel_out_f), .valid_out(valid_out_f), .count(count_f),
    .overflow(overflow_f), .channel_error(channel_error_f), .frame_done(frame_done_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check();
    logic [N+3:0] hd;
    hd = (q.size() != 0) ? q[0] : {(N+4){1'b0}};
    chk("valid_out",       32'(valid_out),       32'(en && q.size() != 0));
    chk("data_out",        32'(data_out),        32'(hd[N+3:4]));
    chk("channel_out",     32'(channel_out),     32'(hd[3:0]));
    chk("count",           32'(count),           32'(q.size()));
    chk("overflow",        32'(overflow),        32'(m_ovf));
    chk("channel_error",   32'(channel_error),   32'(m_cerr));
    chk("frame_done",      32'(frame_done),      32'(m_fd));
    chk("valid_out_f",     32'(valid_out_f),     32'(en && q.size() != 0));
    chk("data_out_f",      32'(data_out_f),      32'(hd[N+3:4]));
    chk("channel_out_f",   32'(channel_out_f),   32'(hd[1:0]));
    chk("count_f",         32'(count_f),         32'(q.size()));
    chk("overflow_f",      32'(overflow_f),      32'(m_ovf));
    chk("channel_error_f", 32'(channel_error_f), 32'(m_cerr_f));
    chk("frame_done_f",    32'(frame_done_f),    32'(m_fd_f));
  endtask

  // One clock: decide model push/pop from the pre-edge inputs, then compare.
  task automatic cycle();
    bit p, pu;
    p  = en && (q.size() != 0) && ready_in;
    pu = en && valid_in && ((q.size() < DEPTH) || p);
    @(posedge clk);
    #1;
    m_fd   = 1'b0;
    m_fd_f = 1'b0;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0; m_cerr = 1'b0; m_cerr_f = 1'b0;
      ch_exp = 0; pc_main = 0; pc_f = 0;
    end else begin
      if (p) begin
        void'(q.pop_front());
        if (pc_main == FL_MAIN - 1) begin pc_main = 0; m_fd = 1'b1; end
        else pc_main++;
        if (pc_f == FL_F - 1) begin pc_f = 0; m_fd_f = 1'b1; end
        else pc_f++;
      end
      if (pu) begin
        q.push_back({data_in, channel_in});
        if (int'(channel_in) != ch_exp) m_cerr = 1'b1;
        if (int'(channel_in[1:0]) != ch_exp % 4) m_cerr_f = 1'b1;
        ch_exp = (ch_exp + 1) % OC;
      end else if (en && valid_in) begin
        m_ovf = 1'b1;
      end
    end
    if (frame_done_f) pulses_f++;
    check();
  endtask

  task automatic push(input int d, input int c);
    valid_in   = 1'b1;
    data_in    = 16'(d);
    channel_in = 4'(c);
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with valid_in asserted
    rst = 1'b1; en = 1'b1; valid_in = 1'b1; ready_in = 1'b1;
    data_in = 16'hABCD; channel_in = 4'd5;
    repeat (2) cycle();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);

    // Streaming with ready high: 1-cycle latency, occupancy stays at most 1
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push(i, i % 16);
      chk("stream_data", 32'(data_out), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    valid_in = 1'b0;
    cycle();

    // Fill with 65 elements, the last is dropped
    ready_in = 1'b0;
    for (int i = 0; i < 65; i++) push(i, i % 16);
    chk("fill_count", 32'(count), 32'd64);
    chk("fill_overflow", 32'(overflow), 32'd1);
    valid_in = 1'b0; ready_in = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("drain_order", 32'(data_out), 32'(i));
      cycle();
    end
    chk("drain_empty", 32'(count), 32'd0);

    // Full with simultaneous push and pop; valid_in with en low is ignored
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 64; i++) push(16'h100 + i, i % 16);
    en = 1'b0; valid_in = 1'b1;
    repeat (2) cycle();
    en = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(16'h200 + i, i % 16);
      chk("fullpp_count", 32'(count), 32'd64);
    end
    valid_in = 1'b0;
    for (int i = 0; i < 64; i++) cycle();
    chk("fullpp_no_overflow", 32'(overflow), 32'd0);

    // Channel sequence 0,1,3 flags an error but still stores data
    do_reset();
    ready_in = 1'b0;
    push(16'h300, 0);
    push(16'h301, 1);
    chk("cherr_before", 32'(channel_error), 32'd0);
    push(16'h303, 3);
    chk("cherr_after", 32'(channel_error), 32'd1);
    chk("cherr_count", 32'(count), 32'd3);
    valid_in = 1'b0; ready_in = 1'b1;
    repeat (3) cycle();

    // Frame of 16 elements on the small instance: exactly one pulse
    do_reset();
    pulses_f = 0;
    for (int i = 0; i < 16; i++) push(16'h400 + i, i % 16);
    valid_in = 1'b0;
    repeat (3) cycle();
    chk("frame_pulses", 32'(pulses_f), 32'd1);

    // Partial frame cut by reset: no pulse, counting restarts from zero
    for (int i = 0; i < 7; i++) push(16'h500 + i, i % 16);
    do_reset();
    chk("midreset_no_pulse", 32'(pulses_f), 32'd1);
    pulses_f = 0;
    for (int i = 0; i < 16; i++) push(16'h600 + i, i % 16);
    valid_in = 1'b0;
    repeat (3) cycle();
    chk("frame_restart_pulses", 32'(pulses_f), 32'd1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 9) != 0);
      valid_in   = ($urandom_range(0, 9) < 7);
      ready_in   = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      data_in    = 16'($urandom);
      channel_in = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'(ch_exp);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
